// File: rtl/id_ex_forward_stage_if.sv
// ID/EX stage bundle: decoded ID fields and EX/MEM producer info in,
// registered EX fields, forwarding selects and hazard status out.
interface id_ex_forward_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 13,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic [REG_W-1:0]  id_dst;
  logic              id_reg_write;
  logic              id_mem_read;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic              flush;
  logic              exmem_reg_write;
  logic [REG_W-1:0]  exmem_dst;

  logic              ex_valid;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic [REG_W-1:0]  ex_dst;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [1:0]        ex_fwd_a;
  logic [1:0]        ex_fwd_b;
  logic              stall;
  logic [CNT_W-1:0]  stall_count;

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dst, id_reg_write,
           id_mem_read, id_rs_data, id_rt_data, id_imm, id_ctrl, flush,
           exmem_reg_write, exmem_dst,
    output ex_valid, ex_reg_write, ex_mem_read, ex_dst, ex_rs_data, ex_rt_data,
           ex_imm, ex_ctrl, ex_fwd_a, ex_fwd_b, stall, stall_count
  );

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dst, id_reg_write,
           id_mem_read, id_rs_data, id_rt_data, id_imm, id_ctrl, flush,
           exmem_reg_write, exmem_dst,
    input  ex_valid, ex_reg_write, ex_mem_read, ex_dst, ex_rs_data, ex_rt_data,
           ex_imm, ex_ctrl, ex_fwd_a, ex_fwd_b, stall, stall_count
  );
endinterface

// File: rtl/id_ex_forward_stage.sv
// ID/EX pipeline register with load-use hazard detection, one-bubble stall,
// EX-operand forwarding select generation and a saturating stall counter.
module id_ex_forward_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 13,
  parameter int CNT_W  = 16
) (
  input  logic clk,
  input  logic rst_n,
  id_ex_forward_stage_if.slave bus
);

  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_EXM = 2'b10;
  localparam logic [1:0] SEL_MWB = 2'b01;

  logic             ex_prod;
  logic             mem_prod;
  logic             ex_load;
  logic             stall;
  logic             bubble;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;

  // The instruction now in EX becomes EX/MEM next cycle, so it is the newest producer.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                         input logic             newer_ok,
                                         input logic [REG_W-1:0] newer_dst,
                                         input logic             older_ok,
                                         input logic [REG_W-1:0] older_dst);
    if (newer_ok && newer_dst == src)      return SEL_EXM;
    else if (older_ok && older_dst == src) return SEL_MWB;
    else                                   return SEL_REG;
  endfunction

  // NOTE: every signal assigned here gets a value on every path, so no latches form.
  always_comb begin
    ex_prod  = bus.ex_valid & bus.ex_reg_write & (bus.ex_dst != '0);
    mem_prod = bus.exmem_reg_write & (bus.exmem_dst != '0);
    ex_load  = bus.ex_valid & bus.ex_mem_read & (bus.ex_dst != '0);
    stall    = bus.id_valid & ~bus.flush &
               ((bus.id_uses_rs & ex_load & (bus.id_rs == bus.ex_dst)) |
                (bus.id_uses_rt & ex_load & (bus.id_rt == bus.ex_dst)));
    bubble   = bus.flush | stall | ~bus.id_valid;
    fwd_a    = bus.id_uses_rs ?
               fwd_sel(bus.id_rs, ex_prod, bus.ex_dst, mem_prod, bus.exmem_dst) : SEL_REG;
    fwd_b    = bus.id_uses_rt ?
               fwd_sel(bus.id_rt, ex_prod, bus.ex_dst, mem_prod, bus.exmem_dst) : SEL_REG;
  end

  assign bus.stall = stall;

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.ex_valid     <= 1'b0;
      bus.ex_reg_write <= 1'b0;
      bus.ex_mem_read  <= 1'b0;
      bus.ex_dst       <= '0;
      bus.ex_ctrl      <= '0;
      bus.ex_fwd_a     <= SEL_REG;
      bus.ex_fwd_b     <= SEL_REG;
      // NOTE: operand registers are cleared too; they are visible outputs, not a memory array.
      bus.ex_rs_data   <= '0;
      bus.ex_rt_data   <= '0;
      bus.ex_imm       <= '0;
      bus.stall_count  <= '0;
    end else begin
      if (stall && bus.stall_count != {CNT_W{1'b1}})
        bus.stall_count <= bus.stall_count + 1'b1;

      if (bubble) begin
        bus.ex_valid     <= 1'b0;
        bus.ex_reg_write <= 1'b0;
        bus.ex_mem_read  <= 1'b0;
        bus.ex_dst       <= '0;
        bus.ex_ctrl      <= '0;
        bus.ex_fwd_a     <= SEL_REG;
        bus.ex_fwd_b     <= SEL_REG;
      end else begin
        bus.ex_valid     <= 1'b1;
        bus.ex_reg_write <= bus.id_reg_write;
        bus.ex_mem_read  <= bus.id_mem_read;
        bus.ex_dst       <= bus.id_dst;
        bus.ex_ctrl      <= bus.id_ctrl;
        bus.ex_fwd_a     <= fwd_a;
        bus.ex_fwd_b     <= fwd_b;
        bus.ex_rs_data   <= bus.id_rs_data;
        bus.ex_rt_data   <= bus.id_rt_data;
        bus.ex_imm       <= bus.id_imm;
      end
    end
  end

endmodule
